// File: rtl/rgb_edge_filter.sv
// RGB edge filter for the pattern-generator -> DVI path.
// Three-stage pipeline: luma, horizontal luma gradient/edge flag, mode-dependent
// output mux. Timing signals travel alongside the pixel so the output stays
// aligned. A per-frame edge counter is published on every vsync leading edge.
module rgb_edge_filter #(
    parameter logic [7:0] THRESH = 8'd32,
    parameter logic       VS_POL = 1'b1
) (
    input  logic        clk_27,
    input  logic        rst_n,
    input  logic [7:0]  rgb_red_in,
    input  logic [7:0]  rgb_green_in,
    input  logic [7:0]  rgb_blue_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        de_in,
    input  logic [1:0]  mode,
    output logic [7:0]  rgb_red,
    output logic [7:0]  rgb_green,
    output logic [7:0]  rgb_blue,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [19:0] edge_count,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        MODE_BYPASS  = 2'b00,
        MODE_GRAY    = 2'b01,
        MODE_EDGE    = 2'b10,
        MODE_OVERLAY = 2'b11
    } mode_t;

    localparam logic SYNC_IDLE = ~VS_POL;

    // Frame-level control
    mode_t       active_mode;
    logic        vs_prev;
    logic        vs_start;
    logic [19:0] edge_acc;

    // Stage 1: luma plus delayed pixel/timing
    logic [15:0] luma_sum;
    logic [7:0]  s1_y;
    logic [7:0]  s1_r;
    logic [7:0]  s1_g;
    logic [7:0]  s1_b;
    logic        s1_hs;
    logic        s1_vs;
    logic        s1_de;

    // Stage 2: gradient and edge flag
    logic [7:0]  grad;
    logic        edge_hit;
    logic [7:0]  s2_y;
    logic [7:0]  s2_r;
    logic [7:0]  s2_g;
    logic [7:0]  s2_b;
    logic        s2_hs;
    logic        s2_vs;
    logic        s2_de;
    logic        s2_e;

    // Stage 3: output mux
    logic [7:0]  px_r;
    logic [7:0]  px_g;
    logic [7:0]  px_b;

    // Leading edge of vsync into its active level marks a new frame
    always_comb begin
        vs_start = (vsync_in == VS_POL) && (vs_prev != VS_POL);
    end

    // Track previous vsync level for leading-edge detection
    always_ff @(posedge clk_27 or negedge rst_n) begin
        if (!rst_n) begin
            vs_prev <= SYNC_IDLE;
        end else begin
            vs_prev <= vsync_in;
        end
    end

    // Mode is only sampled at frame start so a frame never changes style midway
    always_ff @(posedge clk_27 or negedge rst_n) begin
        if (!rst_n) begin
            active_mode <= MODE_BYPASS;
        end else if (vs_start) begin
            active_mode <= mode_t'(mode);
        end
    end

    // Luma weights sum to 256, so the 16-bit sum never overflows
    always_comb begin
        luma_sum = 16'd77  * 16'(rgb_red_in)
                 + 16'd150 * 16'(rgb_green_in)
                 + 16'd29  * 16'(rgb_blue_in);
    end

    // Stage 1 register
    always_ff @(posedge clk_27 or negedge rst_n) begin
        if (!rst_n) begin
            s1_y  <= '0;
            s1_r  <= '0;
            s1_g  <= '0;
            s1_b  <= '0;
            s1_hs <= SYNC_IDLE;
            s1_vs <= SYNC_IDLE;
            s1_de <= 1'b0;
        end else begin
            s1_y  <= luma_sum[15:8];
            s1_r  <= rgb_red_in;
            s1_g  <= rgb_green_in;
            s1_b  <= rgb_blue_in;
            s1_hs <= hsync_in;
            s1_vs <= vsync_in;
            s1_de <= de_in;
        end
    end

    // Gradient against the previous active pixel; s2_de low means this is the
    // first pixel of a line, so no previous luma is used across blanking
    always_comb begin
        grad = '0;
        if (s1_de && s2_de) begin
            grad = (s1_y >= s2_y) ? (s1_y - s2_y) : (s2_y - s1_y);
        end
        edge_hit = s1_de && (grad >= THRESH);
    end

    // Stage 2 register
    always_ff @(posedge clk_27 or negedge rst_n) begin
        if (!rst_n) begin
            s2_y  <= '0;
            s2_r  <= '0;
            s2_g  <= '0;
            s2_b  <= '0;
            s2_hs <= SYNC_IDLE;
            s2_vs <= SYNC_IDLE;
            s2_de <= 1'b0;
            s2_e  <= 1'b0;
        end else begin
            s2_y  <= s1_y;
            s2_r  <= s1_r;
            s2_g  <= s1_g;
            s2_b  <= s1_b;
            s2_hs <= s1_hs;
            s2_vs <= s1_vs;
            s2_de <= s1_de;
            s2_e  <= edge_hit;
        end
    end

    // Select output pixel by mode; blanking always forces black
    always_comb begin
        px_r = s2_r;
        px_g = s2_g;
        px_b = s2_b;
        case (active_mode)
            MODE_GRAY: begin
                px_r = s2_y;
                px_g = s2_y;
                px_b = s2_y;
            end
            MODE_EDGE: begin
                px_r = s2_e ? 8'hFF : 8'h00;
                px_g = s2_e ? 8'hFF : 8'h00;
                px_b = s2_e ? 8'hFF : 8'h00;
            end
            MODE_OVERLAY: begin
                if (s2_e) begin
                    px_r = 8'hFF;
                    px_g = 8'h00;
                    px_b = 8'h00;
                end
            end
            default: begin
            end
        endcase
        if (!s2_de) begin
            px_r = '0;
            px_g = '0;
            px_b = '0;
        end
    end

    // Stage 3 register driving the DVI transmitter
    always_ff @(posedge clk_27 or negedge rst_n) begin
        if (!rst_n) begin
            rgb_red   <= '0;
            rgb_green <= '0;
            rgb_blue  <= '0;
            hsync     <= SYNC_IDLE;
            vsync     <= SYNC_IDLE;
            de        <= 1'b0;
        end else begin
            rgb_red   <= px_r;
            rgb_green <= px_g;
            rgb_blue  <= px_b;
            hsync     <= s2_hs;
            vsync     <= s2_vs;
            de        <= s2_de;
        end
    end

    // Saturating per-frame edge counter; an edge landing on the frame boundary
    // cycle belongs to the new frame
    always_ff @(posedge clk_27 or negedge rst_n) begin
        if (!rst_n) begin
            edge_acc   <= '0;
            edge_count <= '0;
            frame_done <= 1'b0;
        end else if (vs_start) begin
            edge_count <= edge_acc;
            edge_acc   <= {19'd0, s2_e};
            frame_done <= 1'b1;
        end else begin
            frame_done <= 1'b0;
            if (s2_e && (edge_acc != '1)) begin
                edge_acc <= edge_acc + 20'd1;
            end
        end
    end

endmodule

// File: doc/rgb_edge_filter.md
RGB_EDGE_FILTER -- requirements
Module: rgb_edge_filter

Interface
REQ-001 Parameter THRESH, default 8'd32, edge threshold on luma gradient magnitude.
REQ-002 Parameter VS_POL, default 1'b1, active level of vsync_in/vsync_out.
REQ-003 clk_27  input  1  pixel clock, 27 MHz; all logic SHALL be clocked on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 rgb_red_in, rgb_green_in, rgb_blue_in  input  8 each  pixel from the timing/pattern generator.
REQ-006 hsync_in, vsync_in, de_in  input  1 each  generator timing signals.
REQ-007 mode  input  2  processing mode: 00 bypass, 01 gray, 10 binary edge, 11 edge overlay.
REQ-008 rgb_red, rgb_green, rgb_blue  output  8 each  processed pixel to the DVI transmitter.
REQ-009 hsync, vsync, de  output  1 each  timing to the DVI transmitter, delayed to align with the pixel.
REQ-010 edge_count  output  20  number of edge pixels in the last completed frame.
REQ-011 frame_done  output  1  one-cycle pulse when edge_count updates.

Function
REQ-012 Pipeline latency from any input to its output SHALL be exactly 3 clk_27 cycles for pixel, hsync, vsync and de.
REQ-013 Sync polarity SHALL pass through unchanged.
REQ-014 Stage 1 SHALL compute luma Y = (77*R + 150*G + 29*B) >> 8 using a 16-bit unsigned sum, giving an 8-bit result without overflow (white -> 255).
REQ-015 Stage 2 SHALL compute D = |Y - Yprev| (8 bits), where Yprev is the luma of the previous de-active pixel on the same line.
REQ-016 The first de-active pixel of each line (de rising edge) SHALL have D = 0; Yprev SHALL NOT carry across lines or blanking.
REQ-017 Edge flag E = (D >= THRESH); E SHALL be 0 whenever de is 0.
REQ-018 Stage 3 output per mode: 00 -> delayed input RGB; 01 -> R=G=B=Y; 10 -> R=G=B = 255 if E, else 0; 11 -> (255,0,0) if E, else delayed input RGB.
REQ-019 When delayed de is 0, rgb_red/green/blue SHALL be 0 regardless of mode.
REQ-020 Active mode SHALL be latched from the mode input only on the vsync_in transition into the VS_POL level; a mode change mid-frame SHALL NOT affect the current frame.
REQ-021 Internal 20-bit edge accumulator SHALL increment once per stage-3 pixel with E=1 and saturate at 20'hFFFFF.
REQ-022 On the vsync_in transition into the VS_POL level, edge_count SHALL load the accumulator, the accumulator SHALL clear to 0 (or to 1 if an edge pixel is counted the same cycle), and frame_done SHALL pulse high for 1 cycle.
REQ-023 The first vsync edge after reset SHALL also pulse frame_done and load edge_count (value 0 if no edges seen).
REQ-024 Edge counting SHALL be independent of mode (counted in all modes).

Reset
REQ-025 While rst_n=0: all RGB outputs 0, hsync/vsync at ~VS_POL inactive level, de 0, edge_count 0, frame_done 0, active mode 00, all pipeline registers and accumulator 0.
REQ-026 Reset asserted mid-frame SHALL abort immediately; after release, outputs SHALL reflect new inputs after 3 cycles, with the first partial line treated as a new line (D=0 on first pixel).

Verification
REQ-027 Bypass: mode=00 latched, input (12,34,56) with de=1 -> output (12,34,56), de=1 exactly 3 cycles later; hs/vs delayed identically.
REQ-028 Gray: mode=01, input white (255,255,255) -> (255,255,255); input (255,0,0) -> (76,76,76).
REQ-029 Edge: mode=10, line of 4 black pixels then 4 white -> outputs 0,0,0,0,255,0,0,0; first pixel of next line white after white line -> 0.
REQ-030 Overlay and count: mode=11, frame with 10 black/white transitions -> 10 red pixels; at next vsync edge frame_done pulses 1 cycle, edge_count = 10.
REQ-031 Mode mid-frame: change mode 00->10 mid-frame -> remainder of frame stays bypass; edge mode starts at next vsync edge.
REQ-032 Reset: assert rst_n=0 mid-line -> all outputs 0 and vsync inactive within the same cycle; release -> first output pixel appears 3 cycles after de_in, with D=0.
